// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter that time-shares one double-precision adder among NUM_REQ requesters.
// Optional WAIT-state timeout enabled by defining FP_ADD_ARB_TIMEOUT_EN.
module fp_add_arbiter #(
    parameter int NUM_REQ = 4
`ifdef FP_ADD_ARB_TIMEOUT_EN
    , parameter int TIMEOUT = 1024
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [64*NUM_REQ-1:0]        req_a,
    input  logic [64*NUM_REQ-1:0]        req_b,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [63:0]                  rsp_data,
    output logic                         rsp_err,
    output logic [63:0]                  adder_a,
    output logic [63:0]                  adder_b,
    output logic                         adder_ready_in,
    input  logic [63:0]                  adder_out,
    input  logic                         adder_ready_out,
    output logic [1:0]                   o_dbg_state
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [63:0] QNAN = 64'h7FF8000000000000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_last_grant;
    logic [IDW-1:0]   w_gnt_id;
    logic             w_gnt_found;
    logic [IDW:0]     w_cand;
    logic             w_accept;
    logic             r_ready_out_q;
    logic             w_rise;
    logic             w_timeout;
    logic [63:0]      r_adder_a;
    logic [63:0]      r_adder_b;
    logic             r_adder_start;
    logic             r_rsp_valid;
    logic [IDW-1:0]   r_rsp_id;
    logic [63:0]      r_rsp_data;

    // Handshakes: a transfer happens in any cycle where valid and ready are both high;
    // req_ready is a one-hot grant raised only in IDLE, rsp_valid holds its payload until rsp_ready.

    // Search starts one past the last grant so a persistent requester cannot starve the others.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_id    = '0;
        w_cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = {1'b0, r_last_grant} + (IDW+1)'(k);
            if (w_cand >= (IDW+1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDW+1)'(NUM_REQ);
            end
            if (!w_gnt_found && req_valid[w_cand[IDW-1:0]]) begin
                w_gnt_found = 1'b1;
                w_gnt_id    = w_cand[IDW-1:0];
            end
        end
    end

    assign w_accept = (r_state == ST_IDLE) && w_gnt_found;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_gnt_id] = 1'b1;
        end
    end

    // Only a fresh edge counts, so a completion level left over from the last job is ignored.
    assign w_rise = adder_ready_out & ~r_ready_out_q;

`ifdef FP_ADD_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT);
    logic [TMO_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == ST_WAIT) && (r_tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (w_rise || w_timeout) w_state_nxt = ST_RESP;
            ST_RESP:  if (rsp_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= IDW'(NUM_REQ - 1);
            r_ready_out_q <= 1'b1;
            r_adder_a     <= '0;
            r_adder_b     <= '0;
            r_adder_start <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_data    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_ready_out_q <= adder_ready_out;
            r_adder_start <= (w_state_nxt == ST_ISSUE);
            r_rsp_valid   <= (w_state_nxt == ST_RESP);
            if (w_accept) begin
                r_adder_a    <= req_a[{w_gnt_id, 6'd0} +: 64];
                r_adder_b    <= req_b[{w_gnt_id, 6'd0} +: 64];
                r_rsp_id     <= w_gnt_id;
                r_last_grant <= w_gnt_id;
            end
            if (r_state == ST_WAIT) begin
                if (w_rise) begin
                    r_rsp_data <= adder_out;
                end else if (w_timeout) begin
                    r_rsp_data <= QNAN;
                end
            end
        end
    end

`ifdef FP_ADD_ARB_TIMEOUT_EN
    logic r_rsp_err;

    // A completion edge in the timeout cycle still wins and clears the error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_err <= 1'b0;
        end else if (r_state == ST_WAIT) begin
            if (w_rise) begin
                r_rsp_err <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_err <= 1'b1;
            end
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    assign rsp_valid      = r_rsp_valid;
    assign rsp_id         = r_rsp_id;
    assign rsp_data       = r_rsp_data;
    assign adder_a        = r_adder_a;
    assign adder_b        = r_adder_b;
    assign adder_ready_in = r_adder_start;
    assign o_dbg_state    = r_state;

endmodule

// File: doc/fp_add_arbiter.md
# fp_add_arbiter

Round-robin arbiter and sequencer that shares one 64-bit double-precision adder (start pulse `ready_in`, completion signal `ready_out`) among `NUM_REQ` requesters. It accepts one operand pair at a time and issues it to the adder. It waits for completion, then returns the sum tagged with the requester ID over a valid/ready response channel. It sits between the requester-side datapaths and the single adder instance, with at most one operation in flight.

## Interface
- `NUM_REQ`, 4, number of requesters (2..16)
- `TIMEOUT`, 1024, WAIT-state cycle limit; used only when `FP_ADD_ARB_TIMEOUT_EN` is defined
- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: synchronous, active-high reset
- `req_valid` in NUM_REQ: per-requester operand pair valid
- `req_ready` out NUM_REQ: per-requester accept, one-hot or zero
- `req_a` in 64*NUM_REQ: operand A, requester i at bits [64i+63:64i]
- `req_b` in 64*NUM_REQ: operand B, same packing
- `rsp_valid` out 1: result valid
- `rsp_ready` in 1: response consumer accept
- `rsp_id` out $clog2(NUM_REQ): requester index of the result
- `rsp_data` out 64: IEEE-754 double sum
- `rsp_err` out 1: timeout flag, constant 0 without the macro
- `adder_a`, `adder_b` out 64: operands to the adder, registered
- `adder_ready_in` out 1: one-cycle start pulse to the adder
- `adder_out` in 64: adder result
- `adder_ready_out` in 1: adder completion; its rising edge marks the result as valid

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any `req_valid` is set, choose grant g by round-robin, searching from `last_grant+1` modulo NUM_REQ.
  - Drive `req_ready[g]=1` combinationally in that cycle only. The handshake completes in the same cycle.
  - Latch `req_a[g]`, `req_b[g]` into `adder_a`/`adder_b`, latch g as the ID, set `last_grant=g`, and go to ISSUE.
  - If no `req_valid` is set, stay in IDLE.
- ISSUE: drive `adder_ready_in=1` for exactly this cycle, then go to WAIT.
- WAIT:
  - The edge detector is `rise = adder_ready_out & ~ready_out_q`. `ready_out_q` is registered every cycle in every state.
  - On `rise`: capture `adder_out` into `rsp_data`, set `rsp_err=0`, and go to RESP.
  - `rise` seen in IDLE or ISSUE is ignored, so a level held high from the previous operation is never captured.
- RESP:
  - `rsp_valid=1`; `rsp_data`, `rsp_id` and `rsp_err` stay stable until `rsp_ready=1`, then go to IDLE.
  - `req_ready` is 0 in every state except IDLE, so there is no new acceptance while a response is pending.
- `adder_a`/`adder_b` hold their values from ISSUE until the next acceptance.
- Fairness: a requester that keeps `req_valid` asserted is served within NUM_REQ grants.
- Reset values: state=IDLE, `last_grant=NUM_REQ-1` (requester 0 has first priority), `ready_out_q=1`, and all outputs 0.
- Reset mid-operation: any operation in flight is dropped and no response is produced. The adder shares `rst` and restarts as well.

## Timing
- Acceptance in cycle T gives `adder_ready_in` in cycle T+1.
- If the rise is seen in cycle E, `rsp_valid` is first high in cycle E+1.
- The minimum cycle-to-cycle service interval is (E−T)+2, assuming `rsp_ready` is held at 1.
- `req_ready` is combinational from `req_valid` and the state. All other outputs are registered.

## Configuration
- `FP_ADD_ARB_TIMEOUT_EN` defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT−1 with no rise, go to RESP with `rsp_err=1`, `rsp_data=64'h7FF8000000000000` (qNaN) and the original ID.
  - A rise in the same cycle as the timeout wins: normal result, `rsp_err=0`.
- Undefined: no counter; WAIT waits indefinitely; `rsp_err` is tied to 0.

## Test plan
- Single requester 1: A=3FF3AE147AE147AE (1.23), B=40123D70A3D70A3D (4.56).
  - Expected: one `adder_ready_in` pulse, then `rsp_valid` with `rsp_id=1` and `rsp_data`=401728F5C28F5C28 (5.79).
- Requesters 0, 2 and 3 all valid from reset.
  - Expected grant order 0, 2, 3. After requester 0 re-asserts, the order continues 0, 2, 3, never 0, 0.
- Backpressure: hold `rsp_ready=0` for 10 cycles after `rsp_valid` rises.
  - Expected: data and ID stable; `req_ready`=0 throughout; exactly one response after release.
- Stale level: hold `adder_ready_out=1` from before ISSUE until 3 cycles into WAIT, then 0, then a new rise with 40C5DBF10DAE3E6C.
  - Expected: only the new value is returned.
- Reset asserted mid-WAIT.
  - Expected: next cycle state is IDLE, all outputs 0, no response; the next request is served normally.
- With the macro and TIMEOUT=16, the adder never responds.
  - Expected: `rsp_valid` with `rsp_err=1` and `rsp_data`=7FF8000000000000, 16 cycles after WAIT entry.
